// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word geometry, fetch-queue entry layout,
// fetch FSM states and a small saturating-counter helper.
package cpu_pkg;

    localparam int unsigned CPU_WORD  = 4;                   // bytes per instruction word
    localparam int unsigned CPU_WIDTH = 8;                   // bits per byte
    localparam int unsigned CPU_DW    = CPU_WORD * CPU_WIDTH;

    // Fetch FSM: RUN issues and accepts, FLUSH drains stale responses.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_e;

    // One instruction-queue entry.
    typedef struct packed {
        logic [CPU_DW-1:0] inst;
        logic [CPU_DW-1:0] pc;
    } fetch_entry_t;

    // 16-bit increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with zero-latency head, same-cycle push/pop and a
// flush that empties it regardless of concurrent push/pop. Storage is not
// reset; only pointers and occupancy are.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter type          entry_t = fetch_entry_t,
    parameter int unsigned  DEPTH   = 4,
    localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned OW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [OW-1:0] occ,
    output entry_t        head
);

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occ_q;
    logic          push_ok_s, pop_ok_s;

    // Qualify push/pop: flush wins, never overfill, never pop when empty.
    always_comb begin
        push_ok_s = 1'b0;
        pop_ok_s  = 1'b0;
        if (flush) begin
            push_ok_s = 1'b0;
            pop_ok_s  = 1'b0;
        end else begin
            pop_ok_s  = pop && (occ_q != '0);
            push_ok_s = push && ((occ_q < OW'(DEPTH)) || pop_ok_s);
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + PW'(1'b1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + PW'(1'b1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   occ_q <= occ_q + OW'(1'b1);
                2'b01:   occ_q <= occ_q - OW'(1'b1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign occ  = occ_q;
    assign head = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches, tracks outstanding
// in-order responses, queues {inst, pc} for decode and restarts on redirect.
// Optional build macro FETCH_PERF_EN adds saturating flush/stall counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          WORD     = CPU_WORD,
    parameter int unsigned          WIDTH    = CPU_WIDTH,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [WORD*WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redir,
    input  logic [WORD*WIDTH-1:0] redir_pc,
    output logic                  imem_req,
    output logic [WORD*WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [WORD*WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    output logic [WORD*WIDTH-1:0] inst,
    output logic [WORD*WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]           perf_flush_cnt,
    output logic [15:0]           perf_stall_cnt
`endif
);

    localparam int unsigned     DW       = WORD * WIDTH;
    localparam int unsigned     OSW      = $clog2(DEPTH + 1);
    localparam logic [OSW:0]    DEPTH_L  = (OSW + 1)'(DEPTH);
    localparam logic [DW-1:0]   WORD_INC = DW'(WORD);

    fetch_state_e   state_q, state_d;
    logic [OSW-1:0] os_q, os_d;
    logic [DW-1:0]  fa_q, fa_d;
    logic [DW-1:0]  ra_q, ra_d;
    logic [OSW-1:0] occ_s;
    logic [OSW:0]   fill_s;
    logic           fire_s, rsp_s, push_s, pop_s;
    fetch_entry_t   push_entry_s, head_s;

    assign fill_s = {1'b0, occ_s} + {1'b0, os_q};

    // Request gating: only in RUN, not while redirecting, and only while the
    // queue plus in-flight responses still fit. Held low during reset.
    always_comb begin
        imem_req = 1'b0;
        if (rst_n && (state_q == ST_RUN) && !redir && (fill_s < DEPTH_L)) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
    end

    assign imem_addr = fa_q;
    assign fire_s    = imem_req && imem_gnt;
    // A response with nothing outstanding is a memory protocol error; ignore it.
    assign rsp_s     = imem_rvalid && (os_q != '0);
    assign push_s    = (state_q == ST_RUN) && imem_rvalid && !redir;
    assign pop_s     = inst_valid && inst_ready;

    // Next fetch address, response address and outstanding count.
    always_comb begin
        fa_d = fa_q;
        ra_d = ra_q;
        os_d = os_q;
        if (redir) begin
            fa_d = redir_pc;
            ra_d = redir_pc;
        end else begin
            if (fire_s) fa_d = fa_q + WORD_INC;
            else        fa_d = fa_q;
            if (push_s) ra_d = ra_q + WORD_INC;
            else        ra_d = ra_q;
        end
        case ({fire_s, rsp_s})
            2'b10:   os_d = os_q + OSW'(1'b1);
            2'b01:   os_d = os_q - OSW'(1'b1);
            default: os_d = os_q;
        endcase
    end

    // FSM next state: a redirect drains any still-outstanding responses.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (redir) state_d = (os_d != '0) ? ST_FLUSH : ST_RUN;
                else       state_d = ST_RUN;
            end
            ST_FLUSH: begin
                if (redir)              state_d = (os_d != '0) ? ST_FLUSH : ST_RUN;
                else if (os_d == '0)    state_d = ST_RUN;
                else                    state_d = ST_FLUSH;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Fetch state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            os_q    <= '0;
            fa_q    <= RESET_PC;
            ra_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            os_q    <= os_d;
            fa_q    <= fa_d;
            ra_q    <= ra_d;
        end
    end

    assign push_entry_s.inst = imem_rdata;
    assign push_entry_s.pc   = ra_q;

    fetch_fifo #(
        .entry_t (fetch_entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redir),
        .occ       (occ_s),
        .head      (head_s)
    );

    assign inst_valid = (occ_s != '0);
    assign inst       = head_s.inst;
    assign inst_pc    = head_s.pc;

`ifdef FETCH_PERF_EN
    logic [15:0] flush_cnt_q, stall_cnt_q;

    // Saturating counters: redirect cycles and empty-queue cycles in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (redir) flush_cnt_q <= sat_inc16(flush_cnt_q);
            if ((state_q == ST_RUN) && !inst_valid) stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    assign perf_flush_cnt = flush_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// corner sequences, and a randomized run against an epoch-based reference.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk, rst_n, redir, imem_req, imem_gnt, imem_rvalid;
    logic        inst_valid, inst_ready;
    logic [31:0] redir_pc, imem_addr, imem_rdata, inst, inst_pc;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_flush_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_unit #(.WORD(4), .WIDTH(8), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redir       (redir),
        .redir_pc    (redir_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of address.
    function automatic logic [31:0] mdat(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Apply one cycle's inputs and let combinational outputs settle.
    task automatic drive(input logic r, input logic [31:0] rpc, input logic g,
                         input logic rv, input logic [31:0] rd, input logic rdy);
        redir = r; redir_pc = rpc; imem_gnt = g;
        imem_rvalid = rv; imem_rdata = rd; inst_ready = rdy;
        #1;
    endtask

    // Hold reset, check reset outputs, release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req",   {31'h0, imem_req},   32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_addr",  imem_addr,           32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        r;
        logic [31:0] rpc;
        logic        g, rv;
        logic [31:0] rd;
        logic        rdy, e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct { logic [31:0] addr; int epoch; int rdy; } pend_t;
    typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;

    vec_t  vt[10];
    pend_t pend[$];
    ent_t  mq[$];

    initial begin
        int          nreq, cur_epoch, old_cnt, lat, rdyc;
        logic        lp, nlp, e_req, e_valid, r, g, rdy, rv;
        logic [31:0] la, nla, m_fa, rpc;
        pend_t       pe;

        // ---------------- directed table: startup, redirect+rvalid, wrap
        vt[0] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,               1'b1, 1'b1, 32'h0,        1'b0, 32'h0};
        vt[1] = '{1'b0, 32'h0,        1'b1, 1'b1, mdat(32'h0),         1'b1, 1'b1, 32'h4,        1'b0, 32'h0};
        vt[2] = '{1'b0, 32'h0,        1'b1, 1'b1, mdat(32'h4),         1'b1, 1'b1, 32'h8,        1'b1, 32'h0};
        vt[3] = '{1'b1, 32'hFFFFFFFC, 1'b1, 1'b1, mdat(32'h8),         1'b1, 1'b0, 32'hC,        1'b1, 32'h4};
        vt[4] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,               1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0};
        vt[5] = '{1'b0, 32'h0,        1'b1, 1'b1, mdat(32'hFFFFFFFC),  1'b1, 1'b1, 32'h0,        1'b0, 32'h0};
        vt[6] = '{1'b0, 32'h0,        1'b0, 1'b1, mdat(32'h0),         1'b0, 1'b1, 32'h4,        1'b1, 32'hFFFFFFFC};
        vt[7] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,               1'b1, 1'b1, 32'h4,        1'b1, 32'hFFFFFFFC};
        vt[8] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,               1'b1, 1'b1, 32'h4,        1'b1, 32'h0};
        vt[9] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,               1'b1, 1'b1, 32'h4,        1'b0, 32'h0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            drive(vt[i].r, vt[i].rpc, vt[i].g, vt[i].rv, vt[i].rd, vt[i].rdy);
            chk($sformatf("tbl%0d_req", i),   {31'h0, imem_req},   {31'h0, vt[i].e_req});
            chk($sformatf("tbl%0d_valid", i), {31'h0, inst_valid}, {31'h0, vt[i].e_valid});
            if (vt[i].e_req)   chk($sformatf("tbl%0d_addr", i), imem_addr, vt[i].e_addr);
            if (vt[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i),   inst_pc, vt[i].e_pc);
                chk($sformatf("tbl%0d_inst", i), inst,    mdat(vt[i].e_pc));
            end
        end

        // ---------------- queue full with decode stalled, latency-1 memory
        @(negedge clk);
        do_reset();
        nreq = 0; lp = 1'b0; la = 32'h0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            drive(1'b0, 32'h0, 1'b1, lp, mdat(la), 1'b0);
            if (imem_req) begin nreq++; nlp = 1'b1; nla = imem_addr; end
            else          begin nlp = 1'b0; nla = la; end
            lp = nlp; la = nla;
        end
        chk("full_nreq",  nreq,                 32'd4);
        chk("full_req",   {31'h0, imem_req},    32'h0);
        chk("full_pc",    inst_pc,              32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);   // one pop
        chk("full_pop_req", {31'h0, imem_req}, 32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 1'b1, lp, mdat(la), 1'b0);
            if (c == 0) chk("refill_addr", imem_addr, 32'h10);
            if (imem_req) begin nreq++; nlp = 1'b1; nla = imem_addr; end
            else          begin nlp = 1'b0; nla = la; end
            lp = nlp; la = nla;
        end
        chk("refill_nreq", nreq, 32'd5);

        // ---------------- redirect with two responses outstanding
        @(negedge clk);
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("fl_redir_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, mdat(32'h0), 1'b1);
        chk("fl_drop0_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, mdat(32'h4), 1'b1);
        chk("fl_drop1_req",   {31'h0, imem_req},   32'h0);
        chk("fl_drop1_valid", {31'h0, inst_valid}, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("fl_run_req",  {31'h0, imem_req}, 32'h1);
        chk("fl_run_addr", imem_addr,         32'h100);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b1, 1'b1, mdat(32'h100), 1'b1);
        chk("fl_next_addr", imem_addr, 32'h104);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("fl_first_valid", {31'h0, inst_valid}, 32'h1);
        chk("fl_first_pc",    inst_pc,             32'h100);
        chk("fl_first_inst",  inst,                mdat(32'h100));

        // ---------------- randomized run against epoch-based reference
        @(negedge clk);
        do_reset();
        pend.delete(); mq.delete();
        cur_epoch = 0; m_fa = 32'h0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            r   = ($urandom_range(0, 24) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2))
                                              : ($urandom & 32'hFFFF_FFFC);
            g   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            rv  = (pend.size() > 0) && (pend[0].rdy <= cyc);
            drive(r, rpc, g, rv, rv ? mdat(pend[0].addr) : 32'h0, rdy);

            e_valid = (mq.size() != 0);
            old_cnt = 0;
            foreach (pend[k]) if (pend[k].epoch != cur_epoch) old_cnt++;
            e_req = !r && (old_cnt == 0) && ((mq.size() + pend.size()) < DEPTH);

            chk("rnd_valid", {31'h0, inst_valid}, {31'h0, e_valid});
            chk("rnd_req",   {31'h0, imem_req},   {31'h0, e_req});
            if (e_valid) begin
                chk("rnd_pc",   inst_pc, mq[0].pc);
                chk("rnd_inst", inst,    mq[0].inst);
            end
            if (e_req) chk("rnd_addr", imem_addr, m_fa);

            // Reference update for the coming rising edge.
            if (e_valid && rdy) void'(mq.pop_front());
            if (rv) begin
                pe = pend.pop_front();
                if (!r && (pe.epoch == cur_epoch)) mq.push_back('{mdat(pe.addr), pe.addr});
            end
            if (e_req && g) begin
                lat  = $urandom_range(1, 3);
                rdyc = cyc + lat;
                if ((pend.size() > 0) && (rdyc < pend[$].rdy)) rdyc = pend[$].rdy;
                pend.push_back('{m_fa, cur_epoch, rdyc});
                m_fa = m_fa + 32'd4;
            end
            if (r) begin
                mq.delete();
                cur_epoch++;
                m_fa = rpc;
            end
        end

`ifdef FETCH_PERF_EN
        // ---------------- performance counters
        @(negedge clk);
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("perf_rst_flush", {16'h0, perf_flush_cnt}, 32'h0);
        chk("perf_rst_stall", {16'h0, perf_stall_cnt}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1);
            @(negedge clk);
            drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("perf_flush3", {16'h0, perf_flush_cnt}, 32'd3);
        repeat (70000) @(negedge clk);
        #1;
        chk("perf_stall_sat", {16'h0, perf_stall_cnt}, 32'hFFFF);
        chk("perf_flush_keep", {16'h0, perf_flush_cnt}, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
